// File: rtl/nand_ecc_pkg.sv
// Shared constants, state encoding and payload types for the NAND sector Hamming ECC generator.
package nand_ecc_pkg;

  localparam int unsigned PAGE_BYTES = 512;
  localparam int unsigned ADDR_W     = 9;
  localparam int unsigned ECC_W      = 24;
  localparam int unsigned COL_W      = 6;
  localparam int unsigned ECC_BYTES  = 3;

  // Column-parity bit positions within the code; line-parity pairs start at LP_BASE
  localparam int unsigned CP0     = 0;
  localparam int unsigned CP1     = 1;
  localparam int unsigned CP2     = 2;
  localparam int unsigned CP3     = 3;
  localparam int unsigned CP4     = 4;
  localparam int unsigned CP5     = 5;
  localparam int unsigned LP_BASE = 6;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACCUM    = 2'd1,
    ST_LOAD_ECC = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  typedef struct packed {
    logic [COL_W-1:0] col;
    logic             par;
  } byte_par_t;

endpackage

// File: rtl/nand_ecc_byte_par.sv
// Combinational per-byte parity terms: six column parities plus whole-byte parity.
module nand_ecc_byte_par
  import nand_ecc_pkg::*;
(
  input  logic [7:0] data_i,
  output byte_par_t  par_c_o
);

  always_comb begin
    par_c_o          = '0;
    par_c_o.col[CP0] = ^{data_i[6], data_i[4], data_i[2], data_i[0]};
    par_c_o.col[CP1] = ^{data_i[7], data_i[5], data_i[3], data_i[1]};
    par_c_o.col[CP2] = ^{data_i[5], data_i[4], data_i[1], data_i[0]};
    par_c_o.col[CP3] = ^{data_i[7], data_i[6], data_i[3], data_i[2]};
    par_c_o.col[CP4] = ^data_i[3:0];
    par_c_o.col[CP5] = ^data_i[7:4];
    par_c_o.par      = ^data_i;
  end

endmodule

// File: rtl/nand_ecc_gen.sv
// Streaming 24-bit Hamming ECC generator/checker for one 512-byte NAND sector.
// Optional erased-sector detection is enabled by defining NAND_ECC_ERASED_CHK_EN.
module nand_ecc_gen
  import nand_ecc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             data_valid,
  input  logic [7:0]       data_in,
  input  logic             ecc_valid,
  input  logic [7:0]       ecc_byte,
  output logic             busy,
  output logic [ECC_W-1:0] ecc_out,
  output logic [ECC_W-1:0] hamming_result,
  output logic             hamming_en,
  output logic             page_erased
);

  localparam int unsigned       STORED_W  = ECC_W - 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PAGE_BYTES - 1);
  localparam logic [1:0]        LAST_ECC  = 2'(ECC_BYTES - 1);

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     cnt_q, cnt_d;
  logic [1:0]            ecc_cnt_q, ecc_cnt_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [2*ADDR_W-1:0]   lp_q, lp_d;
  logic [STORED_W-1:0]   stored_q, stored_d;
  logic [ECC_W-1:0]      ecc_out_q, ecc_out_d;
  logic [ECC_W-1:0]      result_q, result_d;
  logic                  hamming_en_q, hamming_en_d;
  logic                  busy_q, busy_d;
  logic [ECC_W-1:0]      code_c;
  logic [ECC_W-1:0]      stored_full_c;
  logic                  done_c;
  byte_par_t             bp_c;
`ifdef NAND_ECC_ERASED_CHK_EN
  logic                  all_ff_q, all_ff_d;
  logic                  erased_q, erased_d;
`endif

  nand_ecc_byte_par u_byte_par (
    .data_i  (data_in),
    .par_c_o (bp_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      ecc_cnt_q    <= '0;
      col_q        <= '0;
      lp_q         <= '0;
      stored_q     <= '0;
      ecc_out_q    <= '0;
      result_q     <= '0;
      hamming_en_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef NAND_ECC_ERASED_CHK_EN
      all_ff_q     <= 1'b0;
      erased_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ecc_cnt_q    <= ecc_cnt_d;
      col_q        <= col_d;
      lp_q         <= lp_d;
      stored_q     <= stored_d;
      ecc_out_q    <= ecc_out_d;
      result_q     <= result_d;
      hamming_en_q <= hamming_en_d;
      busy_q       <= busy_d;
`ifdef NAND_ECC_ERASED_CHK_EN
      all_ff_q     <= all_ff_d;
      erased_q     <= erased_d;
`endif
    end
  end

  // Next-state, accumulation and output-register update
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ecc_cnt_d    = ecc_cnt_q;
    col_d        = col_q;
    lp_d         = lp_q;
    stored_d     = stored_q;
    ecc_out_d    = ecc_out_q;
    result_d     = result_q;
    hamming_en_d = 1'b0;
    done_c       = 1'b0;
    code_c       = '0;
    code_c[LP_BASE-1:0]     = col_q;
    code_c[ECC_W-1:LP_BASE] = lp_q;
    stored_full_c = {ecc_byte, stored_q};
`ifdef NAND_ECC_ERASED_CHK_EN
    all_ff_d     = all_ff_q;
    erased_d     = erased_q;
`endif

    case (state_q)
      ST_ACCUM: begin
        if (data_valid) begin
          col_d = col_q ^ bp_c.col;
          // Byte parity lands in the odd bit of pair k when address bit k is set
          for (int unsigned k = 0; k < ADDR_W; k++) begin
            if (cnt_q[k]) lp_d[2*k+1] = lp_q[2*k+1] ^ bp_c.par;
            else          lp_d[2*k]   = lp_q[2*k]   ^ bp_c.par;
          end
          cnt_d = cnt_q + ADDR_W'(1);
          if (cnt_q == LAST_ADDR) state_d = ST_LOAD_ECC;
`ifdef NAND_ECC_ERASED_CHK_EN
          all_ff_d = all_ff_q & (data_in == 8'hFF);
`endif
        end
      end
      ST_LOAD_ECC: begin
        if (ecc_valid) begin
          stored_d  = {ecc_byte, stored_q[STORED_W-1:8]};
          ecc_cnt_d = ecc_cnt_q + 2'd1;
`ifdef NAND_ECC_ERASED_CHK_EN
          all_ff_d  = all_ff_q & (ecc_byte == 8'hFF);
`endif
          if (ecc_cnt_q == LAST_ECC) begin
            ecc_cnt_d = '0;
            state_d   = ST_DONE;
            done_c    = 1'b1;
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Outputs are loaded on the final ECC byte so they are visible during DONE
    if (done_c && !start) begin
      hamming_en_d = 1'b1;
      ecc_out_d    = code_c;
`ifdef NAND_ECC_ERASED_CHK_EN
      erased_d     = all_ff_q & (ecc_byte == 8'hFF);
      result_d     = erased_d ? '0 : (code_c ^ stored_full_c);
`else
      result_d     = code_c ^ stored_full_c;
`endif
    end

    if (start) begin
      state_d   = ST_ACCUM;
      cnt_d     = '0;
      ecc_cnt_d = '0;
      col_d     = '0;
      lp_d      = '0;
      stored_d  = '0;
`ifdef NAND_ECC_ERASED_CHK_EN
      all_ff_d  = 1'b1;
`endif
    end

    busy_d = (state_d == ST_ACCUM) || (state_d == ST_LOAD_ECC);
  end

  assign busy           = busy_q;
  assign ecc_out        = ecc_out_q;
  assign hamming_result = result_q;
  assign hamming_en     = hamming_en_q;
`ifdef NAND_ECC_ERASED_CHK_EN
  assign page_erased    = erased_q;
`else
  assign page_erased    = 1'b0;
`endif

endmodule

// File: tb/tb_nand_ecc_gen.sv
// Self-checking bench for nand_ecc_gen: golden ECC model with a scoreboard of expected DONE results.
module tb_nand_ecc_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        data_valid;
  logic [7:0]  data_in;
  logic        ecc_valid;
  logic [7:0]  ecc_byte;
  logic        busy;
  logic [23:0] ecc_out;
  logic [23:0] hamming_result;
  logic        hamming_en;
  logic        page_erased;

  typedef struct packed {
    logic [23:0] res;
    logic [23:0] code;
    logic        erased;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  sector [512];
  int          checks = 0;
  int          passed = 0;
  int          strobe_cnt = 0;
  int          exp_strobes = 0;

  nand_ecc_gen dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .data_valid     (data_valid),
    .data_in        (data_in),
    .ecc_valid      (ecc_valid),
    .ecc_byte       (ecc_byte),
    .busy           (busy),
    .ecc_out        (ecc_out),
    .hamming_result (hamming_result),
    .hamming_en     (hamming_en),
    .page_erased    (page_erased)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (hamming_en === 1'b1) strobe_cnt++;

  // Reference code built straight from the bit-layout definition
  function automatic logic [23:0] model_ecc();
    logic [23:0] e;
    logic [7:0]  b;
    logic [8:0]  a;
    e = '0;
    for (int i = 0; i < 512; i++) begin
      b = sector[i];
      a = 9'(i);
      e[0] ^= b[0] ^ b[2] ^ b[4] ^ b[6];
      e[1] ^= b[1] ^ b[3] ^ b[5] ^ b[7];
      e[2] ^= b[0] ^ b[1] ^ b[4] ^ b[5];
      e[3] ^= b[2] ^ b[3] ^ b[6] ^ b[7];
      e[4] ^= ^b[3:0];
      e[5] ^= ^b[7:4];
      for (int k = 0; k < 9; k++) begin
        if (a[k]) e[7+2*k] ^= ^b;
        else      e[6+2*k] ^= ^b;
      end
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      data_valid = 1'b1;
      data_in    = sector[i];
      step();
    end
    data_valid = 1'b0;
    data_in    = 8'h00;
  endtask

  // Drives the 3 stored bytes, then checks strobe latency/width and pops the scoreboard
  task automatic send_ecc(input logic [23:0] st, input exp_t e);
    exp_t got;
    for (int j = 0; j < 3; j++) begin
      ecc_valid = 1'b1;
      ecc_byte  = st[8*j +: 8];
      if (j == 2) begin
        exp_q.push_back(e);
        exp_strobes++;
      end
      step();
    end
    ecc_valid = 1'b0;
    ecc_byte  = 8'h00;
    checks++;
    if (hamming_en !== 1'b1) $display("FAIL strobe_latency: hamming_en=%b required 1", hamming_en);
    else passed++;
    if (hamming_en === 1'b1 && exp_q.size() > 0) begin
      got = exp_q.pop_front();
      checks++;
      if (hamming_result !== got.res)
        $display("FAIL hamming_result: got %h required %h", hamming_result, got.res);
      else passed++;
      checks++;
      if (ecc_out !== got.code) $display("FAIL ecc_out: got %h required %h", ecc_out, got.code);
      else passed++;
      checks++;
      if (page_erased !== got.erased)
        $display("FAIL page_erased: got %b required %b", page_erased, got.erased);
      else passed++;
    end
    step();
    checks++;
    if (hamming_en !== 1'b0) $display("FAIL strobe_width: hamming_en=%b required 0", hamming_en);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; data_valid = 1'b0; data_in = 8'h00;
    ecc_valid = 1'b0; ecc_byte = 8'h00;
    repeat (3) step();
    checks++;
    if ({busy, hamming_en, page_erased} !== 3'b000)
      $display("FAIL reset_flags: got %b required 000", {busy, hamming_en, page_erased});
    else passed++;
    checks++;
    if ({ecc_out, hamming_result} !== 48'h0)
      $display("FAIL reset_data: got %h required 0", {ecc_out, hamming_result});
    else passed++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_zero_sector();
    foreach (sector[i]) sector[i] = 8'h00;
    pulse_start();
    checks++;
    if (busy !== 1'b1) $display("FAIL busy_accum: got %b required 1", busy);
    else passed++;
    send_bytes(512);
    send_ecc(24'h000000, '{res: 24'h0, code: 24'h0, erased: 1'b0});
  endtask

  task automatic test_ramp();
    logic [23:0] code;
    foreach (sector[i]) sector[i] = 8'(i);
    code = model_ecc();
    pulse_start();
    send_bytes(512);
    send_ecc(code, '{res: 24'h0, code: code, erased: 1'b0});
  endtask

  task automatic test_single_flip();
    logic [23:0] stored, code;
    logic [11:0] odd;
    foreach (sector[i]) sector[i] = 8'(i);
    stored = model_ecc();
    sector[9'h105] = sector[9'h105] ^ 8'h08;
    code = model_ecc();
    pulse_start();
    send_bytes(512);
    send_ecc(stored, '{res: code ^ stored, code: code, erased: 1'b0});
    checks++;
    if ($countones(hamming_result) != 12)
      $display("FAIL flip_popcount: got %0d required 12", $countones(hamming_result));
    else passed++;
    for (int k = 0; k < 12; k++) odd[k] = hamming_result[2*k+1];
    checks++;
    if (odd !== {9'h105, 3'd3}) $display("FAIL flip_locate: got %h required %h", odd, {9'h105, 3'd3});
    else passed++;
  endtask

  task automatic test_erased();
    foreach (sector[i]) sector[i] = 8'hFF;
    pulse_start();
    send_bytes(512);
`ifdef NAND_ECC_ERASED_CHK_EN
    send_ecc(24'hFFFFFF, '{res: 24'h000000, code: 24'h0, erased: 1'b1});
`else
    send_ecc(24'hFFFFFF, '{res: 24'hFFFFFF, code: 24'h0, erased: 1'b0});
`endif
  endtask

  task automatic test_restart_and_reset();
    logic [23:0] code;
    int          s0;
    foreach (sector[i]) sector[i] = 8'($urandom);
    pulse_start();
    send_bytes(100);
    foreach (sector[i]) sector[i] = 8'(i * 7 + 3);
    code = model_ecc();
    pulse_start();
    send_bytes(512);
    send_ecc(code, '{res: 24'h0, code: code, erased: 1'b0});
    // Reset while in LOAD_ECC must abandon the sector silently
    s0 = strobe_cnt;
    pulse_start();
    send_bytes(512);
    ecc_valid = 1'b1; ecc_byte = code[7:0];
    step();
    rst_n = 1'b0; ecc_byte = code[15:8];
    step();
    ecc_byte = code[23:16];
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0) $display("FAIL rst_busy: got %b required 0", busy);
    else passed++;
    checks++;
    if ({ecc_out, hamming_result} !== 48'h0)
      $display("FAIL rst_clear: got %h required 0", {ecc_out, hamming_result});
    else passed++;
    repeat (3) step();
    ecc_valid = 1'b0; ecc_byte = 8'h00;
    repeat (2) step();
    checks++;
    if (strobe_cnt !== s0) $display("FAIL rst_no_strobe: strobes %0d required %0d", strobe_cnt, s0);
    else passed++;
  endtask

  task automatic test_start_drop();
    logic [23:0] code;
    foreach (sector[i]) sector[i] = 8'(255 - i);
    code = model_ecc();
    pulse_start();
    data_valid = 1'b1; data_in = 8'h11;
    repeat (10) step();
    start = 1'b1; data_in = 8'h5A;
    step();
    start = 1'b0;
    send_bytes(511);
    checks++;
    if (busy !== 1'b1) $display("FAIL drop_busy_511: got %b required 1", busy);
    else passed++;
    data_valid = 1'b1; data_in = sector[511];
    step();
    data_valid = 1'b0;
    send_ecc(code, '{res: 24'h0, code: code, erased: 1'b0});
  endtask

  initial begin
    test_reset();
    test_zero_sector();
    test_ramp();
    test_single_flip();
    test_erased();
    test_restart_and_reset();
    test_start_drop();
    checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_empty: %0d left required 0", exp_q.size());
    else passed++;
    checks++;
    if (strobe_cnt != exp_strobes)
      $display("FAIL strobe_count: got %0d required %0d", strobe_cnt, exp_strobes);
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
